// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - Q-format multiply-accumulate neuron: bias + COUNTER_END beats of in_data*weight.
// Define NEURON_MAC_SAT_EN to saturate the 32-bit result instead of wrapping.
module neuron_mac #(
    parameter int COUNTER_END = 4,
    parameter int FRAC_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] weight,
    output logic [31:0] counter,
    output logic [31:0] mult_sum_out,
    output logic        sum_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [63:0] Q32_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] Q32_MIN = 64'shFFFF_FFFF_8000_0000;

    state_t             r_state;
    logic signed [63:0] r_acc;
    logic [31:0]        r_counter;
    logic [31:0]        r_mult_sum_out;
    logic               r_in_ready;
    logic               r_sum_valid;

    logic signed [63:0] w_data64;
    logic signed [63:0] w_weight64;
    logic signed [63:0] w_prod;
    logic signed [63:0] w_prod_q;
    logic signed [63:0] w_acc_next;
    logic [31:0]        w_conv;
    logic               w_beat;
    logic               w_last;

    assign w_data64   = {{32{in_data[31]}}, in_data};
    assign w_weight64 = {{32{weight[31]}}, weight};
    assign w_prod     = w_data64 * w_weight64;
    assign w_prod_q   = w_prod >>> FRAC_BITS;

    // A start in the same cycle as a beat restarts the run, so the beat is dropped.
    assign w_beat = (r_state == ACCUM) && r_in_ready && in_valid && !start;
    assign w_last = (r_counter == 32'(COUNTER_END - 1));

    always_comb begin
        w_acc_next = r_acc;
        if (start) begin
            w_acc_next = {{32{bias[31]}}, bias};
        end else if (w_beat) begin
            w_acc_next = r_acc + w_prod_q;
        end
    end

    always_comb begin
        w_conv = w_acc_next[31:0];
`ifdef NEURON_MAC_SAT_EN
        if (w_acc_next > Q32_MAX) begin
            w_conv = 32'h7FFF_FFFF;
        end else if (w_acc_next < Q32_MIN) begin
            w_conv = 32'h8000_0000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_counter      <= '0;
            r_mult_sum_out <= '0;
            r_in_ready     <= 1'b0;
            r_sum_valid    <= 1'b0;
        end else begin
            r_acc          <= w_acc_next;
            r_mult_sum_out <= w_conv;
            if (start) begin
                r_state     <= ACCUM;
                r_counter   <= '0;
                r_in_ready  <= 1'b1;
                r_sum_valid <= 1'b0;
            end else begin
                case (r_state)
                    ACCUM: begin
                        if (w_beat) begin
                            r_counter <= r_counter + 32'd1;
                            if (w_last) begin
                                r_state     <= DONE;
                                r_in_ready  <= 1'b0;
                                r_sum_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_in_ready  <= 1'b0;
                        r_sum_valid <= 1'b1;
                    end
                    default: begin
                        r_in_ready  <= 1'b0;
                        r_sum_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign counter      = r_counter;
    assign mult_sum_out = r_mult_sum_out;
    assign sum_valid    = r_sum_valid;

    // Q32_MIN/Q32_MAX are only referenced when saturation is enabled.
    logic w_unused;
    assign w_unused = ^{Q32_MAX, Q32_MIN};

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac against an arithmetic reference model.
module tb_neuron_mac;

    localparam int CE = 4;
    localparam int FB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] weight;
    logic [31:0] counter;
    logic [31:0] mult_sum_out;
    logic        sum_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] da[CE];
    logic [31:0] wa[CE];
    logic [31:0] last_result;
    logic        prev_sv = 1'b0;

    neuron_mac #(.COUNTER_END(CE), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight(weight),
        .counter(counter), .mult_sum_out(mult_sum_out), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] to_q(input longint acc);
`ifdef NEURON_MAC_SAT_EN
        if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    function automatic longint term(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p >>> FB;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising edge of sum_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (sum_valid && !prev_sv) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%08h expected none", mult_sum_out);
            end else begin
                check("result", mult_sum_out, exp_q.pop_front());
                check("result_counter", counter, 32'(CE));
            end
        end
        prev_sv = sum_valid;
    end

    // Runs CE beats from da/wa with idle gaps in [min_gap,max_gap]; optionally issues start first.
    task automatic do_run(input logic [31:0] bias_v, input bit do_start, input int min_gap, input int max_gap);
        longint acc;
        int     gap;
        acc = longint'($signed(bias_v));
        for (int k = 0; k < CE; k++) acc += term(da[k], wa[k]);
        last_result = to_q(acc);
        exp_q.push_back(last_result);
        if (do_start) begin
            start = 1'b1;
            bias  = bias_v;
            tick();
            start = 1'b0;
            bias  = $urandom;
            check("start_counter", counter, 32'd0);
            check("start_sum", mult_sum_out, to_q(longint'($signed(bias_v))));
            check("start_sum_valid", 32'(sum_valid), 32'd0);
        end
        for (int k = 0; k < CE; k++) begin
            gap = $urandom_range(max_gap, min_gap);
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                weight   = $urandom;
                tick();
                check("gap_counter", counter, 32'(k));
            end
            in_valid = 1'b1;
            in_data  = da[k];
            weight   = wa[k];
            check("accum_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check("beat_counter", counter, 32'(k + 1));
        end
        check("done_sum_valid", 32'(sum_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_counter"}, counter, 32'd0);
        check({tag, "_sum"}, mult_sum_out, 32'd0);
        check({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; bias = 32'h1234_5678;
        in_valid = 1'b1; in_data = 32'h0001_0000; weight = 32'h0001_0000;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        check_idle("idle");

        // Back-to-back beats 1.0..4.0 with bias 0.5
        for (int k = 0; k < CE; k++) begin
            da[k] = 32'((k + 1) << 16);
            wa[k] = 32'h0001_0000;
        end
        do_run(32'h0000_8000, 1'b1, 0, 0);
        check("b2b_value", mult_sum_out, 32'h000A_8000);

        // DONE ignores beats
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            weight   = $urandom;
            tick();
            check("hold_counter", counter, 32'(CE));
            check("hold_sum", mult_sum_out, 32'h000A_8000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum_valid", 32'(sum_valid), 32'd1);
        end
        in_valid = 1'b0;

        // Negative products with one idle cycle between beats
        for (int k = 0; k < CE; k++) begin
            da[k] = 32'hFFFF_0000;
            wa[k] = 32'h0002_0000;
        end
        do_run(32'h0, 1'b1, 1, 1);
        check("gapped_value", mult_sum_out, 32'hFFF8_0000);

        // Overflow of the 32-bit range
        for (int k = 0; k < CE; k++) begin
            da[k] = 32'h7FFF_0000;
            wa[k] = 32'h7FFF_0000;
        end
        do_run(32'h0, 1'b1, 0, 0);
`ifdef NEURON_MAC_SAT_EN
        check("overflow_value", mult_sum_out, 32'h7FFF_FFFF);
`else
        check("overflow_value", mult_sum_out, 32'h0004_0000);
`endif

        // Reset after two beats, with start and a beat presented in the reset cycle
        start = 1'b1; bias = 32'h0003_0000;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 32'h0002_0000; weight = 32'h0001_0000;
            tick();
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check_idle("midrst");
        tick();
        check_idle("postrst");
        for (int k = 0; k < CE; k++) begin
            da[k] = 32'h0001_0000;
            wa[k] = 32'h0001_0000;
        end
        do_run(32'h0, 1'b1, 0, 0);
        check("after_rst_value", mult_sum_out, 32'h0004_0000);

        // Restart in ACCUM after 3 beats; the beat in the start cycle is dropped
        start = 1'b1; bias = 32'h0005_0000;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = $urandom; weight = $urandom;
            tick();
        end
        start = 1'b1; bias = 32'h0; in_valid = 1'b1;
        in_data = 32'h0010_0000; weight = 32'h0010_0000;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("abort_counter", counter, 32'd0);
        check("abort_sum", mult_sum_out, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        do_run(32'h0, 1'b0, 0, 0);
        check("abort_value", mult_sum_out, 32'h0004_0000);

        // Randomized runs, restarted straight from DONE
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < CE; k++) begin
                da[k] = (r % 3 == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
                wa[k] = (r % 3 == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
            end
            do_run($urandom, 1'b1, 0, 2);
            check("random_value", mult_sum_out, last_result);
        end

        tick();
        tick();
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter COUNTER_END, default 4: number of input/weight beats accumulated per neuron result.
REQ-002 Parameter FRAC_BITS, default 16: fractional bits of the signed Q-format used by in_data, weight, bias and mult_sum_out.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; loads bias and begins a new accumulation.
REQ-006 bias  input  32  signed Q bias, sampled on the start cycle only.
REQ-007 in_valid  input  1  in_data/weight beat present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  32  signed Q activation operand.
REQ-010 weight  input  32  signed Q weight operand.
REQ-011 counter  output  32  count of beats accepted since the last start, 0..COUNTER_END.
REQ-012 mult_sum_out  output  32  signed Q accumulated sum, final when counter == COUNTER_END.
REQ-013 sum_valid  output  1  high while the final result is held.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-015 IDLE: in_ready=0, sum_valid=0; start -> ACCUM, accumulator <= sign-extended bias, counter <= 0.
REQ-016 ACCUM: in_ready=1; a beat is accepted on in_valid && in_ready.
REQ-017 Accepted beat: 64-bit signed product in_data*weight, arithmetic right shift by FRAC_BITS, added to a 64-bit signed accumulator; counter += 1.
REQ-018 Beat gaps (in_valid=0) SHALL hold accumulator and counter unchanged.
REQ-019 The beat that makes counter == COUNTER_END SHALL move the FSM to DONE on the same edge; in_ready deasserts the following cycle.
REQ-020 mult_sum_out and counter SHALL be registered and reflect the accepted beat one cycle after it is accepted (latency 1); sum_valid asserts in that same cycle.
REQ-021 DONE: in_ready=0, sum_valid=1, counter held at COUNTER_END, mult_sum_out held until the next start or rst.
REQ-022 start in DONE SHALL behave as in IDLE (reload bias, counter 0, -> ACCUM, sum_valid drops next cycle).
REQ-023 start in ACCUM SHALL abort and restart: accumulator <= bias, counter <= 0; any beat presented that cycle is discarded.
REQ-024 mult_sum_out SHALL always equal the 32-bit conversion (see Configuration) of the current accumulator.

Reset
REQ-025 rst SHALL override all inputs including start: state IDLE, accumulator 0, counter 0, mult_sum_out 0, sum_valid 0, in_ready 0 on the next edge.
REQ-026 rst asserted mid-ACCUM SHALL discard the partial sum; no beat is accepted in the rst cycle.

Configuration
REQ-027 Macro NEURON_MAC_SAT_EN defined: 32-bit conversion clamps accumulator to 0x7FFFFFFF if above, 0x80000000 if below signed 32-bit range.
REQ-028 Macro NEURON_MAC_SAT_EN undefined: 32-bit conversion takes accumulator bits [31:0] (two's-complement wrap).

Verification (FRAC_BITS=16, COUNTER_END=4)
REQ-029 bias 0x00008000, in_data 1.0,2.0,3.0,4.0 (0x00010000..0x00040000), weight 0x00010000 each, back-to-back -> mult_sum_out 0x000A8000, counter 4, sum_valid 1 one cycle after 4th beat.
REQ-030 bias 0, in_data 0xFFFF0000, weight 0x00020000 x4 with one idle cycle between each beat -> mult_sum_out 0xFFF80000, counter steps 1,2,3,4 only on accepted beats.
REQ-031 bias 0, in_data = weight = 0x7FFF0000 x4 -> with NEURON_MAC_SAT_EN 0x7FFFFFFF; without 0x00040000.
REQ-032 rst pulsed after 2 accepted beats, then start with bias 0 and 4 beats of 1.0*1.0 -> mult_sum_out 0x00040000; outputs read 0 and IDLE immediately after rst.
REQ-033 start reasserted in ACCUM after 3 beats while in_valid=1 -> that beat dropped, counter 0, new run of 4 beats 1.0*1.0 with bias 0 -> 0x00040000.
REQ-034 In DONE, in_valid held high 5 cycles -> counter stays 4, mult_sum_out unchanged, in_ready 0.
